// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scan_chain_ctrl
//  Purpose  : Sequences one posedge scan chain. It serially loads a test
//             pattern on TI with TE=1 and unloads the previous chain contents
//             from SO. Optional TE-low capture cycles follow. The unloaded
//             response is then presented on resp/resp_valid.
//  Options  : SCAN_CTRL_MISR_EN adds a 16-bit MISR signature (sig) over SO
//             with an IDLE-only clear (sig_clr).
//  Revision : 1.0  initial release
// ============================================================================
module scan_chain_ctrl #(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 1
`ifdef SCAN_CTRL_MISR_EN
  ,
  parameter logic [15:0] MISR_POLY = 16'h1021
`endif
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic [CHAIN_LEN-1:0] pattern,
  output logic                 ready,
  output logic                 TE,
  output logic                 TI,
  input  logic                 SO,
`ifdef SCAN_CTRL_MISR_EN
  input  logic                 sig_clr,
  output logic [15:0]          sig,
`endif
  output logic                 cap_active,
  output logic [CHAIN_LEN-1:0] resp,
  output logic                 resp_valid
);

  localparam int CW  = $clog2(CHAIN_LEN + 1);
  localparam int CCW = (CAPTURE_CYCLES > 0) ? $clog2(CAPTURE_CYCLES + 1) : 1;

  localparam logic [CW-1:0]  SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CCW-1:0] CAP_LAST   = CCW'((CAPTURE_CYCLES > 0) ? CAPTURE_CYCLES - 1 : 0);
  localparam logic           CAP_ON     = (CAPTURE_CYCLES > 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CCW-1:0]       ccnt_q, ccnt_d;
  // Pattern bits still to be sent; bit0 was already placed on TI at accept.
  logic [CHAIN_LEN-2:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] rsp_q, rsp_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 cap_en_q, cap_en_d;
  logic                 ready_q, ready_d;
  logic                 te_q, te_d;
  logic                 ti_q, ti_d;
  logic                 capact_q, capact_d;
  logic                 valid_q, valid_d;

  // Response shifter after this edge's SO sample (first sampled bit lands in bit0).
  logic [CHAIN_LEN-1:0] w_rsp_shift;
  assign w_rsp_shift = {SO, rsp_q[CHAIN_LEN-1:1]};

  // Next-state logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ccnt_d   = ccnt_q;
    pat_d    = pat_q;
    rsp_d    = rsp_q;
    resp_d   = resp_q;
    cap_en_d = cap_en_q;
    ready_d  = ready_q;
    te_d     = te_q;
    ti_d     = ti_q;
    capact_d = capact_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start && ready_q) begin
          pat_d    = pattern[CHAIN_LEN-1:1];
          cap_en_d = capture_en;
          cnt_d    = '0;
          ready_d  = 1'b0;
          valid_d  = 1'b0;
          te_d     = 1'b1;
          ti_d     = pattern[0];
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        rsp_d = w_rsp_shift;
        pat_d = pat_q >> 1;
        ti_d  = pat_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == SHIFT_LAST) begin
          te_d = 1'b0;
          ti_d = 1'b0;
          if (cap_en_q && CAP_ON) begin
            capact_d = 1'b1;
            ccnt_d   = '0;
            state_d  = S_CAPTURE;
          end else begin
            resp_d  = w_rsp_shift;
            valid_d = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_CAPTURE: begin
        ccnt_d = ccnt_q + CCW'(1);
        if (ccnt_q == CAP_LAST) begin
          capact_d = 1'b0;
          resp_d   = rsp_q;
          valid_d  = 1'b1;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; async reset returns to an idle, chain-quiet state.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ccnt_q   <= '0;
      pat_q    <= '0;
      rsp_q    <= '0;
      resp_q   <= '0;
      cap_en_q <= 1'b0;
      ready_q  <= 1'b1;
      te_q     <= 1'b0;
      ti_q     <= 1'b0;
      capact_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ccnt_q   <= ccnt_d;
      pat_q    <= pat_d;
      rsp_q    <= rsp_d;
      resp_q   <= resp_d;
      cap_en_q <= cap_en_d;
      ready_q  <= ready_d;
      te_q     <= te_d;
      ti_q     <= ti_d;
      capact_q <= capact_d;
      valid_q  <= valid_d;
    end
  end

  assign ready      = ready_q;
  assign TE         = te_q;
  assign TI         = ti_q;
  assign cap_active = capact_q;
  assign resp       = resp_q;
  assign resp_valid = valid_q;

`ifdef SCAN_CTRL_MISR_EN
  logic [15:0] sig_q, sig_d;

  // Signature next state: compress SO on shift edges, clear only while idle.
  always_comb begin
    sig_d = sig_q;
    if (state_q == S_SHIFT) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ {15'b0, SO};
    end else if ((state_q == S_IDLE) && sig_clr) begin
      sig_d = '0;
    end
  end

  // Signature register.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_chain_ctrl
//  Purpose  : Directed bench for scan_chain_ctrl (CHAIN_LEN=8). Instance A
//             uses CAPTURE_CYCLES=1 and instance B uses CAPTURE_CYCLES=0.
//             Each instance drives an 8-flop scan chain model whose
//             functional path is D=~Q. The MISR checks follow
//             SCAN_CTRL_MISR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic       CLK = 1'b0;
  logic       R   = 1'b0;

  logic       start_a = 1'b0, cap_a = 1'b0;
  logic [7:0] pat_a   = 8'h00;
  logic       ready_a, te_a, ti_a, so_a, capact_a, valid_a;
  logic [7:0] resp_a;

  logic       start_b = 1'b0, cap_b = 1'b0;
  logic [7:0] pat_b   = 8'h00;
  logic       ready_b, te_b, ti_b, so_b, capact_b, valid_b;
  logic [7:0] resp_b;

`ifdef SCAN_CTRL_MISR_EN
  logic        sig_clr_a = 1'b0;
  logic        sig_clr_b = 1'b0;
  logic [15:0] sig_a, sig_b;
`endif

  logic [7:0] chain_a = 8'h00;
  logic [7:0] chain_b = 8'h00;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut_a (
    .CLK(CLK), .R(R), .start(start_a), .capture_en(cap_a), .pattern(pat_a),
    .ready(ready_a), .TE(te_a), .TI(ti_a), .SO(so_a),
`ifdef SCAN_CTRL_MISR_EN
    .sig_clr(sig_clr_a), .sig(sig_a),
`endif
    .cap_active(capact_a), .resp(resp_a), .resp_valid(valid_a)
  );

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(0)) dut_b (
    .CLK(CLK), .R(R), .start(start_b), .capture_en(cap_b), .pattern(pat_b),
    .ready(ready_b), .TE(te_b), .TI(ti_b), .SO(so_b),
`ifdef SCAN_CTRL_MISR_EN
    .sig_clr(sig_clr_b), .sig(sig_b),
`endif
    .cap_active(capact_b), .resp(resp_b), .resp_valid(valid_b)
  );

  // Chain models: shift when TE=1, functional D=~Q only during capture, else hold.
  assign so_a = chain_a[7];
  assign so_b = chain_b[7];
  always @(posedge CLK) begin
    if (te_a)          chain_a <= {chain_a[6:0], ti_a};
    else if (capact_a) chain_a <= ~chain_a;
    if (te_b)          chain_b <= {chain_b[6:0], ti_b};
    else if (capact_b) chain_b <= ~chain_b;
  end

  // Observation mux so one task can drive either instance.
  logic       sel = 1'b0;
  logic       m_ready, m_te, m_ti, m_cap, m_valid;
  logic [7:0] m_resp;
  assign m_ready = sel ? ready_b  : ready_a;
  assign m_te    = sel ? te_b     : te_a;
  assign m_ti    = sel ? ti_b     : ti_a;
  assign m_cap   = sel ? capact_b : capact_a;
  assign m_valid = sel ? valid_b  : valid_a;
  assign m_resp  = sel ? resp_b   : resp_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit which, input bit st, input logic [7:0] pat, input bit cap);
    if (which) begin start_b = st; pat_b = pat; cap_b = cap; end
    else       begin start_a = st; pat_a = pat; cap_a = cap; end
  endtask

  // One load/unload operation, starting and ending at a sample point.
  task automatic op(input bit which, input logic [7:0] pat, input bit cap, input bit hold,
                    input bit chk_resp, input logic [7:0] exp_resp,
                    input int exp_lat, input int exp_cap, input string tag);
    int lat, te_hi, cap_n, ti_bad;
    sel = which;
    chk({tag, "_rdy_pre"}, 32'(m_ready), 32'd1);
    drive(which, 1'b1, pat, cap);
    @(posedge CLK); #1;
    if (!hold) drive(which, 1'b0, pat, cap);
    chk({tag, "_busy"}, 32'(m_ready), 32'd0);
    lat = 0; te_hi = 0; cap_n = 0; ti_bad = 0;
    while (!m_valid && lat < 40) begin
      if (m_te) begin
        if (te_hi >= N || m_ti !== pat[te_hi]) ti_bad++;
        te_hi++;
      end
      if (m_cap) cap_n++;
      @(posedge CLK); #1;
      lat++;
    end
    if (hold) drive(which, 1'b0, pat, cap);
    chk({tag, "_lat"},   32'(lat),    32'(exp_lat));
    chk({tag, "_te_hi"}, 32'(te_hi),  32'(N));
    chk({tag, "_ti"},    32'(ti_bad), 32'd0);
    chk({tag, "_capn"},  32'(cap_n),  32'(exp_cap));
    chk({tag, "_te_end"}, 32'(m_te),  32'd0);
    chk({tag, "_rdy"},   32'(m_ready), 32'd1);
    if (chk_resp) chk({tag, "_resp"}, 32'(m_resp), 32'(exp_resp));
  endtask

  initial begin
    int lat;
`ifdef SCAN_CTRL_MISR_EN
    logic [15:0] msig;
    logic [7:0]  prev;
`endif
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(ready_a),  32'd1);
    chk("rst_te",    32'(te_a),     32'd0);
    chk("rst_ti",    32'(ti_a),     32'd0);
    chk("rst_cap",   32'(capact_a), 32'd0);
    chk("rst_resp",  32'(resp_a),   32'd0);
    chk("rst_valid", 32'(valid_a),  32'd0);
    @(negedge CLK); R = 1'b1;
    @(posedge CLK); #1;

    // Plain load/unload round trip
    op(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 8, 0, "t1a");
    op(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 8, 0, "t1b");

    // One capture cycle inverts the loaded pattern
    op(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'h3C, 9, 1, "t2a");
    op(1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 8'h5A, 8, 0, "t2b");

    // start held during shift is ignored; back-to-back accept
    op(1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h96, 8, 0, "t3a");
    sel = 1'b0;
    drive(1'b0, 1'b1, 8'h0F, 1'b0);
    chk("t3_resp_pre", 32'(resp_a), 32'h96);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 8'h0F, 1'b0);
    chk("t3_valid_drop", 32'(valid_a), 32'd0);
    chk("t3_busy",       32'(ready_a), 32'd0);
    chk("t3_resp_hold",  32'(resp_a),  32'h96);
    lat = 0;
    while (!valid_a && lat < 40) begin @(posedge CLK); #1; lat++; end
    chk("t3_lat",  32'(lat),    32'd8);
    chk("t3_resp", 32'(resp_a), 32'hC3);

    // Asynchronous reset in the middle of a shift
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 8'h5A, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t4_te_pre", 32'(te_a), 32'd1);
    R = 1'b0;
    #1;
    chk("t4_te",    32'(te_a),    32'd0);
    chk("t4_ti",    32'(ti_a),    32'd0);
    chk("t4_ready", 32'(ready_a), 32'd1);
    chk("t4_valid", 32'(valid_a), 32'd0);
    @(negedge CLK); R = 1'b1;
    @(posedge CLK); #1;
    op(1'b0, 8'hE7, 1'b0, 1'b0, 1'b0, 8'h00, 8, 0, "t4a");
    op(1'b0, 8'h18, 1'b0, 1'b0, 1'b1, 8'hE7, 8, 0, "t4b");

`ifdef SCAN_CTRL_MISR_EN
    // Signature over the unloaded bits of 8'h18
    sig_clr_a = 1'b1;
    @(posedge CLK); #1;
    sig_clr_a = 1'b0;
    chk("t6_sig_clr", 32'(sig_a), 32'd0);
    op(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h18, 8, 0, "t6a");
    prev = 8'h18;
    msig = 16'h0000;
    for (int i = 0; i < N; i++) begin
      msig = {msig[14:0], 1'b0} ^ (msig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, prev[i]};
    end
    chk("t6_sig", 32'(sig_a), 32'(msig));
`endif

    // CAPTURE_CYCLES=0: capture request yields no TE-low gap
    op(1'b1, 8'h69, 1'b1, 1'b0, 1'b1, 8'h00, 8, 0, "t5a");
    op(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h69, 8, 0, "t5b");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
